// File: rtl/sdram_arbiter.sv
// Multi-port round-robin front end for the single-channel sdram driver.
// Queued refresh wins over ports; each port has its own ack pulse and read-data register.
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 8,
    parameter int LATENCY   = 5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] din,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS*DATA_W-1:0] dout,
    input  logic                        refresh,
    output logic                        busy,
    output logic                        fail,
    output logic [19:0]                 total_written,
    output logic [ADDR_W:0]             mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    output logic                        mem_rd,
    output logic                        mem_wr,
    output logic                        mem_refresh,
    input  logic [DATA_W-1:0]           mem_dout,
    input  logic                        mem_busy,
    input  logic                        mem_data_ready
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT} state_t;

    state_t                           state_reg, state_next;
    logic [PW-1:0]                    last_reg, last_next;
    logic [PW-1:0]                    port_reg, port_next;
    logic [CW-1:0]                    cnt_reg, cnt_next;
    logic                             pend_reg, pend_next;
    logic                             port_op_reg, port_op_next;
    logic                             rd_op_reg, rd_op_next;
    logic [NUM_PORTS-1:0]             ack_reg, ack_next;
    logic [NUM_PORTS-1:0][DATA_W-1:0] dout_reg, dout_next;
    logic                             fail_reg, fail_next;
    logic [19:0]                      tw_reg, tw_next;
    logic [ADDR_W:0]                  maddr_reg, maddr_next;
    logic [DATA_W-1:0]                mdin_reg, mdin_next;
    logic                             mrd_reg, mrd_next;
    logic                             mwr_reg, mwr_next;
    logic                             mref_reg, mref_next;

    logic [ADDR_W-1:0] addr_arr [NUM_PORTS];
    logic [DATA_W-1:0] din_arr  [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]              = addr[gi*ADDR_W +: ADDR_W];
            assign din_arr[gi]               = din[gi*DATA_W +: DATA_W];
            assign dout[gi*DATA_W +: DATA_W] = dout_reg[gi];
        end
    endgenerate

    logic [NUM_PORTS-1:0] elig;
    logic                 gnt_valid;
    logic [PW-1:0]        gnt_idx;
    logic [PW:0]          cand;

    always_comb begin
        elig      = req & ~ack_reg;
        gnt_valid = 1'b0;
        gnt_idx   = last_reg;
        cand      = '0;
        // Scan farthest-first so the eligible port nearest after last wins.
        for (int i = NUM_PORTS; i >= 1; i--) begin
            cand = {1'b0, last_reg} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_PORTS))
                cand = cand - (PW+1)'(NUM_PORTS);
            if (elig[cand[PW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        port_next    = port_reg;
        cnt_next     = cnt_reg;
        pend_next    = pend_reg | refresh;
        port_op_next = port_op_reg;
        rd_op_next   = rd_op_reg;
        ack_next     = '0;
        dout_next    = dout_reg;
        fail_next    = fail_reg;
        tw_next      = tw_reg;
        maddr_next   = maddr_reg;
        mdin_next    = mdin_reg;
        mrd_next     = 1'b0;
        mwr_next     = 1'b0;
        mref_next    = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (!mem_busy)
                    state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_reg) begin
                    mref_next    = 1'b1;
                    pend_next    = refresh;
                    port_op_next = 1'b0;
                    rd_op_next   = 1'b0;
                    cnt_next     = CW'(1);
                    state_next   = ST_WAIT;
                end else if (gnt_valid) begin
                    maddr_next   = {1'b0, addr_arr[gnt_idx]};
                    mdin_next    = din_arr[gnt_idx];
                    mwr_next     = we[gnt_idx];
                    mrd_next     = ~we[gnt_idx];
                    last_next    = gnt_idx;
                    port_next    = gnt_idx;
                    port_op_next = 1'b1;
                    rd_op_next   = ~we[gnt_idx];
                    cnt_next     = CW'(1);
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == CW'(LATENCY)) begin
                    if (port_op_reg) begin
                        ack_next[port_reg] = 1'b1;
                        if (rd_op_reg) begin
                            dout_next[port_reg] = mem_dout;
                            if (!mem_data_ready)
                                fail_next = 1'b1;
                        end else begin
                            tw_next = tw_reg + 20'd1;
                        end
                    end
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_INIT;
            last_reg    <= PW'(NUM_PORTS - 1);
            port_reg    <= '0;
            cnt_reg     <= '0;
            pend_reg    <= 1'b0;
            port_op_reg <= 1'b0;
            rd_op_reg   <= 1'b0;
            ack_reg     <= '0;
            dout_reg    <= '0;
            fail_reg    <= 1'b0;
            tw_reg      <= '0;
            maddr_reg   <= '0;
            mdin_reg    <= '0;
            mrd_reg     <= 1'b0;
            mwr_reg     <= 1'b0;
            mref_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            port_reg    <= port_next;
            cnt_reg     <= cnt_next;
            pend_reg    <= pend_next;
            port_op_reg <= port_op_next;
            rd_op_reg   <= rd_op_next;
            ack_reg     <= ack_next;
            dout_reg    <= dout_next;
            fail_reg    <= fail_next;
            tw_reg      <= tw_next;
            maddr_reg   <= maddr_next;
            mdin_reg    <= mdin_next;
            mrd_reg     <= mrd_next;
            mwr_reg     <= mwr_next;
            mref_reg    <= mref_next;
        end
    end

    assign ack           = ack_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign fail          = fail_reg;
    assign total_written = tw_reg;
    assign mem_addr      = maddr_reg;
    assign mem_din       = mdin_reg;
    assign mem_rd        = mrd_reg;
    assign mem_wr        = mwr_reg;
    assign mem_refresh   = mref_reg;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a monitor logs driver commands and acks,
// and each scenario compares those logs against the expectations it queued.
module tb_sdram_arbiter;
    localparam int N   = 3;
    localparam int AW  = 22;
    localparam int DW  = 8;
    localparam int LAT = 5;
    localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_REF = 2'd2;

    typedef struct { int cyc; logic [1:0] kind; logic [AW:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { int cyc; int port; logic [DW-1:0] d; } ack_t;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] din = '0;
    logic [N-1:0]    ack;
    logic [N*DW-1:0] dout;
    logic            refresh = 1'b0;
    logic            busy, fail;
    logic [19:0]     total_written;
    logic [AW:0]     mem_addr;
    logic [DW-1:0]   mem_din;
    logic            mem_rd, mem_wr, mem_refresh;
    logic [DW-1:0]   mem_dout = '0;
    logic            mem_busy = 1'b1;
    logic            mem_data_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [DW-1:0] model   [256];
    logic          written [256];
    cmd_t cmd_q[$], exp_cmd[$];
    ack_t ack_q[$], exp_ack[$];

    sdram_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .din(din),
        .ack(ack), .dout(dout), .refresh(refresh), .busy(busy), .fail(fail),
        .total_written(total_written), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_dout(mem_dout), .mem_busy(mem_busy), .mem_data_ready(mem_data_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [7:0] k);
        return k ^ 8'h5A;
    endfunction

    // Driver model: writes land in the array, reads return data on the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            model[mem_addr[7:0]]   <= mem_din;
            written[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_rd)
            mem_dout <= (written[mem_addr[7:0]] === 1'b1) ? model[mem_addr[7:0]]
                                                          : init_val(mem_addr[7:0]);
    end

    always @(negedge clk) begin
        if (mem_rd)      cmd_q.push_back('{cyc, K_RD, mem_addr, mem_din});
        if (mem_wr)      cmd_q.push_back('{cyc, K_WR, mem_addr, mem_din});
        if (mem_refresh) cmd_q.push_back('{cyc, K_REF, mem_addr, mem_din});
        for (int i = 0; i < N; i++)
            if (ack[i]) ack_q.push_back('{cyc, i, dout[i*DW +: DW]});
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[p]            = w;
        addr[p*AW +: AW] = a;
        din[p*DW +: DW]  = d;
    endtask

    task automatic clear_queues();
        cmd_q.delete(); exp_cmd.delete(); ack_q.delete(); exp_ack.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0; req = '0; we = '0; refresh = 1'b0;
        mem_busy = 1'b0; mem_data_ready = 1'b1;
        repeat (2) step();
        resetn = 1'b1;
        repeat (2) step();
        clear_queues();
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int k = 0;
        while (ack_q.size() < n && k < budget) begin step(); k++; end
        checks++;
        if (ack_q.size() < n) begin
            errors++;
            $display("FAIL %s ack_timeout: got %0d acks, expected %0d", tag, ack_q.size(), n);
        end
    endtask

    task automatic wait_cmds(input int n, input int budget, input string tag);
        int k = 0;
        while (cmd_q.size() < n && k < budget) begin step(); k++; end
        checks++;
        if (cmd_q.size() < n) begin
            errors++;
            $display("FAIL %s cmd_timeout: got %0d cmds, expected %0d", tag, cmd_q.size(), n);
        end
    endtask

    task automatic test_reset();
        int busy_bad = 0;
        cmd_t c, e;
        ack_t a, ea;
        int pc[$];
        int prev = -1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset busy: got %b expected 1", busy); end
        checks++;
        if ({mem_rd, mem_wr, mem_refresh, ack} !== '0 || mem_addr !== '0 || mem_din !== '0) begin
            errors++;
            $display("FAIL reset mem_outputs: rd=%b wr=%b ref=%b ack=%b addr=%h din=%h expected all 0",
                     mem_rd, mem_wr, mem_refresh, ack, mem_addr, mem_din);
        end
        checks++;
        if (fail !== 1'b0 || total_written !== 20'd0 || dout !== '0) begin
            errors++;
            $display("FAIL reset status: fail=%b tw=%0d dout=%h expected 0", fail, total_written, dout);
        end
        clear_queues();
        set_port(0, 1'b0, 22'h000100, 8'h00);
        req[0] = 1'b1; refresh = 1'b1; resetn = 1'b1;
        step();
        refresh = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b1) busy_bad++;
            step();
        end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL init busy_held: got %0d low cycles expected 0", busy_bad); end
        checks++;
        if (cmd_q.size() !== 0) begin errors++; $display("FAIL init no_strobe: got %0d cmds expected 0", cmd_q.size()); end
        exp_cmd.push_back('{0, K_REF, '0, '0});
        exp_cmd.push_back('{0, K_RD, 23'h000100, '0});
        exp_ack.push_back('{0, 0, init_val(8'h00)});
        mem_busy = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL init exit busy: got %b expected 0", busy); end
        wait_acks(1, 40, "init");
        req = '0;
        repeat (LAT + 3) step();
        checks++;
        if (cmd_q.size() !== exp_cmd.size()) begin
            errors++; $display("FAIL init cmd_count: got %0d expected %0d", cmd_q.size(), exp_cmd.size());
        end
        while (cmd_q.size() > 0 && exp_cmd.size() > 0) begin
            c = cmd_q.pop_front(); e = exp_cmd.pop_front();
            checks++;
            if (c.kind !== e.kind || (e.kind !== K_REF && c.a !== e.a) || (prev >= 0 && c.cyc - prev !== LAT + 1)) begin
                errors++;
                $display("FAIL init cmd: got kind=%0d addr=%h gap=%0d expected kind=%0d addr=%h gap=%0d",
                         c.kind, c.a, c.cyc - prev, e.kind, e.a, LAT + 1);
            end
            if (c.kind !== K_REF) pc.push_back(c.cyc);
            prev = c.cyc;
        end
        checks++;
        if (ack_q.size() !== 1) begin errors++; $display("FAIL init ack_count: got %0d expected 1", ack_q.size()); end
        if (ack_q.size() > 0 && pc.size() > 0) begin
            a = ack_q.pop_front(); ea = exp_ack.pop_front();
            checks++;
            if (a.port !== ea.port || a.d !== ea.d || a.cyc - pc[0] !== LAT) begin
                errors++;
                $display("FAIL init ack: got port=%0d d=%h lat=%0d expected port=%0d d=%h lat=%0d",
                         a.port, a.d, a.cyc - pc[0], ea.port, ea.d, LAT);
            end
        end
    endtask

    task automatic test_write_read();
        cmd_t c, e;
        ack_t a, ea;
        int pc[$];
        do_reset();
        set_port(1, 1'b1, 22'h3C0010, 8'hA5);
        req[1] = 1'b1;
        exp_cmd.push_back('{0, K_WR, {1'b0, 22'h3C0010}, 8'hA5});
        exp_ack.push_back('{0, 1, 8'h00});
        wait_acks(1, 40, "wr_rd");
        set_port(1, 1'b0, 22'h3C0010, 8'h00);
        exp_cmd.push_back('{0, K_RD, {1'b0, 22'h3C0010}, 8'h00});
        exp_ack.push_back('{0, 1, 8'hA5});
        wait_acks(2, 40, "wr_rd");
        req = '0;
        repeat (LAT + 3) step();
        checks++;
        if (cmd_q.size() !== 2) begin errors++; $display("FAIL wr_rd cmd_count: got %0d expected 2", cmd_q.size()); end
        while (cmd_q.size() > 0 && exp_cmd.size() > 0) begin
            c = cmd_q.pop_front(); e = exp_cmd.pop_front();
            checks++;
            if (c.kind !== e.kind || c.a !== e.a || (e.kind == K_WR && c.d !== e.d)) begin
                errors++;
                $display("FAIL wr_rd cmd: got kind=%0d addr=%h din=%h expected kind=%0d addr=%h din=%h",
                         c.kind, c.a, c.d, e.kind, e.a, e.d);
            end
            pc.push_back(c.cyc);
        end
        while (ack_q.size() > 0 && exp_ack.size() > 0 && pc.size() > 0) begin
            a = ack_q.pop_front(); ea = exp_ack.pop_front();
            checks++;
            if (a.port !== ea.port || a.d !== ea.d || a.cyc - pc[0] !== LAT) begin
                errors++;
                $display("FAIL wr_rd ack: got port=%0d d=%h lat=%0d expected port=%0d d=%h lat=%0d",
                         a.port, a.d, a.cyc - pc[0], ea.port, ea.d, LAT);
            end
            void'(pc.pop_front());
        end
        checks++;
        if (total_written !== 20'd1) begin errors++; $display("FAIL wr_rd total_written: got %0d expected 1", total_written); end
    endtask

    task automatic test_round_robin();
        cmd_t c, e;
        ack_t a, ea;
        int pc[$];
        int prev = -1;
        do_reset();
        for (int i = 0; i < N; i++) set_port(i, 1'b0, AW'(32'h100 + i), 8'h00);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                exp_cmd.push_back('{0, K_RD, (AW+1)'(32'h100 + i), 8'h00});
                exp_ack.push_back('{0, i, init_val(8'(i))});
            end
        req = '1;
        wait_cmds(6, 120, "rr");
        req = '0;
        wait_acks(6, 40, "rr");
        repeat (LAT + 3) step();
        checks++;
        if (cmd_q.size() !== 6) begin errors++; $display("FAIL rr cmd_count: got %0d expected 6", cmd_q.size()); end
        while (cmd_q.size() > 0 && exp_cmd.size() > 0) begin
            c = cmd_q.pop_front(); e = exp_cmd.pop_front();
            checks++;
            if (c.kind !== e.kind || c.a !== e.a || (prev >= 0 && c.cyc - prev !== LAT + 1)) begin
                errors++;
                $display("FAIL rr grant: got kind=%0d addr=%h gap=%0d expected kind=%0d addr=%h gap=%0d",
                         c.kind, c.a, c.cyc - prev, e.kind, e.a, LAT + 1);
            end
            pc.push_back(c.cyc);
            prev = c.cyc;
        end
        checks++;
        if (ack_q.size() !== 6) begin errors++; $display("FAIL rr ack_count: got %0d expected 6", ack_q.size()); end
        while (ack_q.size() > 0 && exp_ack.size() > 0 && pc.size() > 0) begin
            a = ack_q.pop_front(); ea = exp_ack.pop_front();
            checks++;
            if (a.port !== ea.port || a.d !== ea.d || a.cyc - pc[0] !== LAT) begin
                errors++;
                $display("FAIL rr ack: got port=%0d d=%h lat=%0d expected port=%0d d=%h lat=%0d",
                         a.port, a.d, a.cyc - pc[0], ea.port, ea.d, LAT);
            end
            void'(pc.pop_front());
        end
    endtask

    task automatic test_refresh();
        cmd_t c, e;
        ack_t a, ea;
        int pc[$];
        int prev = -1;
        do_reset();
        set_port(0, 1'b0, 22'h000100, 8'h00);
        set_port(2, 1'b0, 22'h000102, 8'h00);
        exp_cmd.push_back('{0, K_RD, 23'h000100, 8'h00});
        exp_cmd.push_back('{0, K_REF, '0, 8'h00});
        exp_cmd.push_back('{0, K_RD, 23'h000102, 8'h00});
        exp_ack.push_back('{0, 0, init_val(8'h00)});
        exp_ack.push_back('{0, 2, init_val(8'h02)});
        req[0] = 1'b1;
        wait_cmds(1, 20, "refresh");
        req[2] = 1'b1; refresh = 1'b1;
        step();
        refresh = 1'b0;
        wait_acks(1, 40, "refresh");
        req[0] = 1'b0;
        wait_acks(2, 40, "refresh");
        req[2] = 1'b0;
        repeat (LAT + 3) step();
        checks++;
        if (cmd_q.size() !== 3) begin errors++; $display("FAIL refresh cmd_count: got %0d expected 3", cmd_q.size()); end
        while (cmd_q.size() > 0 && exp_cmd.size() > 0) begin
            c = cmd_q.pop_front(); e = exp_cmd.pop_front();
            checks++;
            if (c.kind !== e.kind || (e.kind !== K_REF && c.a !== e.a) || (prev >= 0 && c.cyc - prev !== LAT + 1)) begin
                errors++;
                $display("FAIL refresh order: got kind=%0d addr=%h gap=%0d expected kind=%0d addr=%h gap=%0d",
                         c.kind, c.a, c.cyc - prev, e.kind, e.a, LAT + 1);
            end
            if (c.kind !== K_REF) pc.push_back(c.cyc);
            prev = c.cyc;
        end
        checks++;
        if (ack_q.size() !== 2) begin errors++; $display("FAIL refresh ack_count: got %0d expected 2", ack_q.size()); end
        while (ack_q.size() > 0 && exp_ack.size() > 0 && pc.size() > 0) begin
            a = ack_q.pop_front(); ea = exp_ack.pop_front();
            checks++;
            if (a.port !== ea.port || a.d !== ea.d || a.cyc - pc[0] !== LAT) begin
                errors++;
                $display("FAIL refresh ack: got port=%0d d=%h lat=%0d expected port=%0d d=%h lat=%0d",
                         a.port, a.d, a.cyc - pc[0], ea.port, ea.d, LAT);
            end
            void'(pc.pop_front());
        end
    endtask

    task automatic test_fail_flag();
        do_reset();
        checks++;
        if (fail !== 1'b0) begin errors++; $display("FAIL fail_flag initial: got %b expected 0", fail); end
        mem_data_ready = 1'b0;
        set_port(0, 1'b0, 22'h000005, 8'h00);
        req[0] = 1'b1;
        wait_acks(1, 40, "fail_flag");
        req[0] = 1'b0;
        mem_data_ready = 1'b1;
        checks++;
        if (fail !== 1'b1) begin errors++; $display("FAIL fail_flag set: got %b expected 1", fail); end
        checks++;
        if (dout[0 +: DW] !== init_val(8'h05)) begin
            errors++; $display("FAIL fail_flag dout: got %h expected %h", dout[0 +: DW], init_val(8'h05));
        end
        repeat (2) step();
        set_port(0, 1'b0, 22'h000006, 8'h00);
        req[0] = 1'b1;
        wait_acks(2, 40, "fail_flag");
        req[0] = 1'b0;
        repeat (2) step();
        checks++;
        if (fail !== 1'b1 || dout[0 +: DW] !== init_val(8'h06)) begin
            errors++;
            $display("FAIL fail_flag sticky: got fail=%b dout=%h expected fail=1 dout=%h",
                     fail, dout[0 +: DW], init_val(8'h06));
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        set_port(0, 1'b1, 22'h000040, 8'h11);
        req[0] = 1'b1;
        wait_acks(1, 40, "reset_mid");
        req[0] = 1'b0;
        checks++;
        if (total_written !== 20'd1) begin errors++; $display("FAIL reset_mid pre_tw: got %0d expected 1", total_written); end
        repeat (2) step();
        clear_queues();
        set_port(1, 1'b1, 22'h000030, 8'h33);
        req[1] = 1'b1;
        wait_cmds(1, 20, "reset_mid");
        repeat (2) step();
        resetn = 1'b0;
        #1;
        checks++;
        if (ack !== '0 || dout !== '0 || mem_addr !== '0 || mem_din !== '0 || {mem_rd, mem_wr, mem_refresh} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid outputs: ack=%b dout=%h addr=%h din=%h strobes=%b expected all 0",
                     ack, dout, mem_addr, mem_din, {mem_rd, mem_wr, mem_refresh});
        end
        checks++;
        if (busy !== 1'b1 || fail !== 1'b0 || total_written !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid status: busy=%b fail=%b tw=%0d expected busy=1 fail=0 tw=0",
                     busy, fail, total_written);
        end
        req = '0;
        repeat (LAT + 3) step();
        checks++;
        if (ack_q.size() !== 0) begin errors++; $display("FAIL reset_mid ack_seen: got %0d acks expected 0", ack_q.size()); end
        mem_busy = 1'b1;
        resetn = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1 || cmd_q.size() !== 1) begin
            errors++;
            $display("FAIL reset_mid init: busy=%b cmds=%0d expected busy=1 cmds=1", busy, cmd_q.size());
        end
        mem_busy = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || total_written !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid idle: busy=%b tw=%0d expected busy=0 tw=0", busy, total_written);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_refresh();
        test_fail_flag();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
